// File: rtl/axi_stream_arbiter.sv
// Round-robin arbiter merging NUM_INPUTS AXI-Stream slaves onto one master port.
// Latency: 1 cycle request-to-grant, 0 cycles data (pure mux), one IDLE bubble per grant.
// Backpressure: master tready is passed straight to the granted slave; all others see 0.
module axi_stream_arbiter #(
    parameter int NUM_INPUTS  = 4,
    parameter int TDATA_WIDTH = 16,
    parameter int TUSER_WIDTH = 1,
    parameter bit USE_TLAST   = 1
) (
    input  logic                               aclk,
    input  logic                               areset,
    input  logic [NUM_INPUTS*TDATA_WIDTH-1:0]  tdata_s_in,
    input  logic [NUM_INPUTS*(TDATA_WIDTH/8)-1:0] tstrb_s_in,
    input  logic [NUM_INPUTS-1:0]              tlast_s_in,
    input  logic [NUM_INPUTS*TUSER_WIDTH-1:0]  tuser_s_in,
    input  logic [NUM_INPUTS-1:0]              tvalid_s_in,
    output logic [NUM_INPUTS-1:0]              tready_s_out,
    output logic [TDATA_WIDTH-1:0]             tdata_m_out,
    output logic [TDATA_WIDTH/8-1:0]           tstrb_m_out,
    output logic                               tlast_m_out,
    output logic [TUSER_WIDTH-1:0]             tuser_m_out,
    output logic                               tvalid_m_out,
    input  logic                               tready_m_in,
    output logic [NUM_INPUTS-1:0]              grant_out,
    output logic                               busy_out
);
    localparam int IDX_W  = $clog2(NUM_INPUTS);
    localparam int STRB_W = TDATA_WIDTH / 8;

    typedef enum logic {IDLE, GRANT} state_t;

    typedef struct packed {
        logic [TDATA_WIDTH-1:0] tdata;
        logic [STRB_W-1:0]      tstrb;
        logic                   tlast;
        logic [TUSER_WIDTH-1:0] tuser;
        logic                   tvalid;
    } beat_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] last_grant, last_grant_nxt;
    logic [IDX_W-1:0] grant_idx, grant_idx_nxt;
    logic [IDX_W-1:0] cand, sel_idx;
    logic             sel_found;
    logic             xfer;
    beat_t            m_beat;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int off = 1; off <= NUM_INPUTS; off++) begin
            cand = IDX_W'((int'(last_grant) + off) % NUM_INPUTS);
            if (!sel_found && tvalid_s_in[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        m_beat       = '0;
        grant_out    = '0;
        tready_s_out = '0;
        if (state == GRANT) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (grant_idx == IDX_W'(i)) begin
                    m_beat.tdata    = tdata_s_in[i*TDATA_WIDTH +: TDATA_WIDTH];
                    m_beat.tstrb    = tstrb_s_in[i*STRB_W +: STRB_W];
                    m_beat.tlast    = tlast_s_in[i];
                    m_beat.tuser    = tuser_s_in[i*TUSER_WIDTH +: TUSER_WIDTH];
                    m_beat.tvalid   = tvalid_s_in[i];
                    grant_out[i]    = 1'b1;
                    tready_s_out[i] = tready_m_in;
                end
            end
        end
    end

    assign tdata_m_out  = m_beat.tdata;
    assign tstrb_m_out  = m_beat.tstrb;
    assign tlast_m_out  = m_beat.tlast;
    assign tuser_m_out  = m_beat.tuser;
    assign tvalid_m_out = m_beat.tvalid;
    assign busy_out     = (state == GRANT);
    assign xfer         = m_beat.tvalid & tready_m_in;

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        grant_idx_nxt  = grant_idx;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_nxt     = GRANT;
                    grant_idx_nxt = sel_idx;
                end
            end
            GRANT: begin
                if (xfer && (USE_TLAST == 1'b0 || m_beat.tlast)) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = grant_idx;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NUM_INPUTS - 1);
            grant_idx  <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            grant_idx  <= grant_idx_nxt;
        end
    end
endmodule
